// File: rtl/steer_en_ctrl.sv
// Rider-presence / steering-enable controller for the segway.
// Watches left/right load cells and the battery reading, and decides
// when steering may be enabled, when the rider has left, and when the
// battery is low.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   lft_ld    in   [11:0] left load cell, unsigned
//   rght_ld   in   [11:0] right load cell, unsigned
//   batt      in   [11:0] battery reading, unsigned
//   en_steer  out  steering enabled (registered, high in STEER)
//   rider_off out  one-cycle pulse when rider leaves (registered)
//   batt_low  out  batt < BATT_THRES (registered)
//
// Build option: STEER_FAST_SIM_EN forces a 15-bit settle timer
// (32767-cycle settle) regardless of TMR_BITS.

module steer_en_ctrl #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter logic [11:0] BATT_THRES   = 12'h800,
  parameter int          TMR_BITS     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic [11:0] batt,
  output logic        en_steer,
  output logic        rider_off,
  output logic        batt_low
);

`ifdef STEER_FAST_SIM_EN
  localparam int TW = 15;
`else
  localparam int TW = TMR_BITS;
`endif

  localparam logic [12:0] THR_HI =
    {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
  localparam logic [12:0] THR_LO =
    {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  state_t state, nxt;

  logic [12:0]   sum;
  logic [11:0]   diff;
  logic          sum_gt_min;
  logic          sum_lt_min;
  logic          diff_gt_1_4;
  logic          diff_gt_15_16;
  logic [TW-1:0] tmr;
  logic          tmr_full;
  logic          clr_tmr;
  logic          off_nxt;

  assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld)
                                    : (rght_ld - lft_ld);

  assign sum_gt_min    = sum > THR_HI;
  assign sum_lt_min    = sum < THR_LO;
  assign diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
  assign diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));

  assign tmr_full = &tmr;

  // Saturating settle timer; held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmr <= '0;
    else if (clr_tmr || state == IDLE)
      tmr <= '0;
    else if (!tmr_full)
      tmr <= tmr + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt     = state;
    clr_tmr = 1'b0;
    off_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (sum_gt_min) begin
          nxt     = WAIT;
          clr_tmr = 1'b1;
        end
      end
      WAIT: begin
        if (sum_lt_min) begin
          nxt     = IDLE;
          off_nxt = 1'b1;
        end else if (diff_gt_1_4) begin
          clr_tmr = 1'b1;
        end else if (tmr_full) begin
          nxt = STEER;
        end
      end
      STEER: begin
        if (sum_lt_min) begin
          nxt     = IDLE;
          off_nxt = 1'b1;
        end else if (diff_gt_15_16) begin
          nxt     = WAIT;
          clr_tmr = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs registered off the next-state so en_steer tracks the
  // state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_steer  <= 1'b0;
      rider_off <= 1'b0;
      batt_low  <= 1'b0;
    end else begin
      en_steer  <= (nxt == STEER);
      rider_off <= off_nxt;
      batt_low  <= (batt < BATT_THRES);
    end
  end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Scoreboard bench for steer_en_ctrl: two instances (15-bit and
// 4-bit settle timers) share stimulus and are checked every cycle.

module tb_steer_en_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        en_a, off_a, low_a;
  logic        en_b, off_b, low_b;

  always #5 clk = ~clk;

  steer_en_ctrl #(.TMR_BITS(15)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .batt      (batt),
    .en_steer  (en_a),
    .rider_off (off_a),
    .batt_low  (low_a)
  );

  steer_en_ctrl #(.TMR_BITS(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .batt      (batt),
    .en_steer  (en_b),
    .rider_off (off_b),
    .batt_low  (low_b)
  );

  typedef enum {M_IDLE, M_WAIT, M_STEER} mst_t;

  mst_t       m_st [2];
  int         m_cnt [2];
  int         m_full [2];
  logic [2:0] q_a [$];
  logic [2:0] q_b [$];
  int         passed = 0;
  int         total  = 0;

  task automatic chk(input string n, input logic [2:0] got,
                     input logic [2:0] exp);
    total++;
    if (got === exp)
      passed++;
    else
      $display("FAIL %s t=%0t en/off/low got=%b want=%b",
               n, $time, got, exp);
  endtask

  // Monitor: pops one expectation per instance after every edge.
  always @(posedge clk) begin
    #1;
    if (q_a.size() == 0) begin
      total++;
      $display("FAIL dut_a_underflow t=%0t got=empty want=entry",
               $time);
    end else
      chk("dut_a", {en_a, off_a, low_a}, q_a.pop_front());
    if (q_b.size() == 0) begin
      total++;
      $display("FAIL dut_b_underflow t=%0t got=empty want=entry",
               $time);
    end else
      chk("dut_b", {en_b, off_b, low_b}, q_b.pop_front());
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i]  = M_IDLE;
      m_cnt[i] = 0;
    end
  endtask

  // One clock of the behavioural rider model, then the edge.
  task automatic step();
    int l, r, s, d;
    bit gt, lt, d14, d1516, off;
    logic [2:0] e;
    l     = lft_ld;
    r     = rght_ld;
    s     = l + r;
    d     = (l > r) ? l - r : r - l;
    gt    = s > 'h240;
    lt    = s < 'h1C0;
    d14   = d > s / 4;
    d1516 = d > s - s / 16;
    for (int i = 0; i < 2; i++) begin
      off = 1'b0;
      case (m_st[i])
        M_IDLE: begin
          m_cnt[i] = 0;
          if (gt) m_st[i] = M_WAIT;
        end
        M_WAIT: begin
          if (lt) begin
            m_st[i] = M_IDLE;
            off     = 1'b1;
          end else if (d14)
            m_cnt[i] = 0;
          else if (m_cnt[i] == m_full[i])
            m_st[i] = M_STEER;
          else
            m_cnt[i]++;
        end
        default: begin
          if (lt) begin
            m_st[i] = M_IDLE;
            off     = 1'b1;
          end else if (d1516) begin
            m_st[i]  = M_WAIT;
            m_cnt[i] = 0;
          end
        end
      endcase
      e = {m_st[i] == M_STEER, off, batt < 12'h800};
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic rst_step();
    model_reset();
    q_a.push_back(3'b000);
    q_b.push_back(3'b000);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int l, input int r, input int n);
    lft_ld  = 12'(l);
    rght_ld = 12'(r);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    m_full[0] = 32767;
    m_full[1] = 15;
    model_reset();
    rst_n   = 1'b0;
    lft_ld  = '0;
    rght_ld = '0;
    batt    = 12'h900;
    #2;
    chk("reset_a", {en_a, off_a, low_a}, 3'b000);
    chk("reset_b", {en_b, off_b, low_b}, 3'b000);
    rst_step();
    rst_step();
    rst_n = 1'b1;
    hold('h000, 'h000, 3);

    // Balanced rider until the long timer settles.
    hold('h200, 'h200, 32780);

    // Heavy imbalance in STEER drops back to WAIT.
    hold('h3F0, 'h008, 1);

    // Wobble at WAIT cycle 10000 restarts the settle.
    hold('h200, 'h200, 10000);
    hold('h300, 'h100, 1);
    hold('h200, 'h200, 32780);

    // Sum on the lower threshold holds; below it the rider leaves.
    hold('h0E0, 'h0E0, 5);
    hold('h0D0, 'h0D0, 3);

    // Mid-operation reset with the short-timer instance in STEER.
    batt = 12'h700;
    hold('h200, 'h200, 25);
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", {en_a, off_a, low_a}, 3'b000);
    chk("async_rst_b", {en_b, off_b, low_b}, 3'b000);
    rst_step();
    rst_n = 1'b1;
    hold('h200, 'h200, 25);

    // Battery threshold sweep.
    batt = 12'h801;
    step();
    batt = 12'h7FF;
    step();
    batt = 12'h800;
    step();
    step();

    // Randomised load patterns held for short bursts.
    for (int b = 0; b < 200; b++) begin
      int base, dl, l, r;
      batt = 12'($urandom_range('h7F0, 'h810));
      case ($urandom_range(0, 3))
        0: begin
          base = $urandom_range('h0C0, 'h180);
          l = base;
          r = base;
        end
        1: begin
          l = $urandom_range(0, 'hFFF);
          r = $urandom_range(0, 'hFFF);
        end
        2: begin
          base = $urandom_range('h100, 'h400);
          dl   = $urandom_range(0, 'h80);
          l    = base + dl;
          r    = base;
        end
        default: begin
          l = 0;
          r = 0;
        end
      endcase
      hold(l, r, $urandom_range(1, 24));
    end

    total++;
    if (q_a.size() == 0 && q_b.size() == 0)
      passed++;
    else
      $display("FAIL drain got=%0d/%0d want=0/0",
               q_a.size(), q_b.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
